fetch_aligner: RTL and testbench
================================

# fetch_aligner

Instruction-fetch front end between word-wide instruction memory and decode. It fetches 32-bit aligned words and buffers them as halfwords. It extracts one instruction per handshake, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. Compressed halfwords are routed through the external `decompressor`, so decode always receives a 32-bit `instruction_type`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of first instruction after reset; bit 0 ignored.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  redirect request (branch/jump taken); overrides all other activity.
- `flush_pc`  in  32  redirect target; bit 0 ignored.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch word address, bits [1:0] always 0.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  read data valid; exactly one response per accepted request, ≥1 cycle after acceptance.
- `imem_resp_data`  in  32  read word, little-endian (halfword 0 = bits [15:0]).
- `dec_in`  out  16  halfword driven into the `decompressor` `input_instruction`.
- `dec_out`  in  32  `decompressor` `output_instruction`, combinational from `dec_in`.
- `instr_valid`  out  1  instruction available.
- `instr_ready`  in  1  decode accepts instruction.
- `instr`  out  32  expanded instruction.
- `instr_pc`  out  32  byte PC of `instr`.
- `instr_compressed`  out  1  1 = came from a 16-bit encoding (next PC +2).

## Operation
- **Queue:** halfword FIFO, depth 4, `count` 0..4. `head_pc` is the PC of the head entry.
- **Fetch FSM states:**
  - IDLE: `imem_req_valid` = `run` & (`count` ≤ 2) & !`flush`. On accept, go to WAIT and set `fetch_addr` += 4.
  - WAIT: on `imem_resp_valid`, push the halfwords and go to IDLE.
  - DISCARD: on `imem_resp_valid`, drop the data and go to IDLE.
- **Push rule:** push both halfwords, except when `drop_low` is set. In that case push only halfword 1 and clear `drop_low`.
- **Head decode:**
  - `head[1:0]` ≠ 2'b11 and `count` ≥ 1 → compressed. `dec_in` = head, `instr` = `dec_out`, consume 1 on handshake, `head_pc` += 2.
  - `head[1:0]` = 2'b11 and `count` ≥ 2 → 32-bit. `instr` = {entry1, head}, consume 2 on handshake, `head_pc` += 4.
  - Otherwise `instr_valid` = 0.
- `dec_in` always carries the head halfword (0 when empty).
- **Handshake:** an instruction transfers when `instr_valid` & `instr_ready`. Push and pop in the same cycle are both applied: `count` = `count` + pushed − popped.
- **Flush:**
  - Empty the queue, `head_pc` = {`flush_pc`[31:1],0}, `fetch_addr` = {`flush_pc`[31:2],00}, `drop_low` = `flush_pc`[1].
  - FSM: WAIT → DISCARD; DISCARD stays DISCARD; IDLE stays IDLE.
  - A response arriving in the flush cycle is discarded, and the FSM then goes to IDLE.
  - No request is issued and `instr_valid` = 0 in the flush cycle.
- **Outstanding requests:** at most one. `count` ≤ 2 at issue guarantees no overflow.
- `imem_req_addr` = `fetch_addr`, held stable while `imem_req_valid` & !`imem_req_ready`.

## Timing
- **Reset (asynchronous):**
  - Registers: `count` = 0, FSM = IDLE, `run` = 0, `head_pc` = RESET_PC & ~1, `fetch_addr` = RESET_PC & ~3, `drop_low` = RESET_PC[1].
  - Outputs: `imem_req_valid` = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = `head_pc`, `instr_compressed` = 0.
- `run` sets on the first edge after `reset_n` rises, so the first request appears in cycle 1 after release.
- Response in cycle N → `instr_valid` in N+1 (queue registered). No combinational path from `imem_resp_*` to `instr_*`.
- `instr_valid`, `instr`, `instr_pc` and `instr_compressed` are stable while `instr_valid` & !`instr_ready`, unless `flush`.
- Sustained throughput: one 32-bit or two 16-bit instructions per 2 cycles with a 1-cycle memory.
- Reset mid-WAIT: the late response is ignored, because the FSM is IDLE and does not accept data.

## Test plan
- **Reset, aligned fetch:** RESET_PC=0, mem[0]=32'h00A00093 → request addr 0; `instr`=32'h00A00093, `instr_pc`=0, `instr_compressed`=0.
- **Two compressed in one word:** mem[0]=32'h05054505, with the real `decompressor` →
  - pc 0: `dec_in`=16'h4505, `instr`=32'h00100513, `instr_compressed`=1.
  - pc 2: `instr`=32'h00150513.
- **Straddle:** mem[0]=32'h00934505, mem[4]=32'h000100A0 →
  - pc 0: 32'h00100513.
  - pc 2: 32'h00A00093, `instr_compressed`=0, produced only after the second word arrives.
- **Flush with response outstanding:** `flush`=1, `flush_pc`=32'h102 while in WAIT →
  - The stale response is dropped.
  - Next request addr 32'h100, whose low halfword is dropped.
  - First `instr_pc`=32'h102.
- **Decode backpressure:** `instr_ready`=0 for 6 cycles with 16-bit instructions →
  - Outputs stable.
  - `count` stops at ≤4.
  - `imem_req_valid`=0 whenever `count`>2.
  - No instruction lost or duplicated after release.
- **Memory stall:** `imem_req_ready`=0 for 4 cycles → `imem_req_valid`=1 and `imem_req_addr` constant throughout; exactly one response consumed afterwards.

Source files
------------

// File: rtl/fetch_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fetch_aligner                                            |
// | Description : Instruction-fetch front end. Fetches aligned 32-bit words,|
// |               buffers them as halfwords and hands decode one 16-bit    |
// |               (expanded via the external decompressor) or 32-bit       |
// |               instruction per handshake, including word straddles.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [15:0] dec_in,
  input  logic [31:0] dec_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  localparam int unsigned c_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_run;
  logic [2:0]  r_count;
  logic [15:0] r_q [c_DEPTH];
  logic [31:0] r_head_pc;
  logic [31:0] r_fetch_addr;
  logic        r_drop_low;

  logic [15:0] w_head;
  logic [15:0] w_entry1;
  logic        w_is32;
  logic        w_valid;
  logic [1:0]  w_pop_n;
  logic [1:0]  w_push_n;
  logic        w_req_valid;
  logic        w_accept;
  logic [2:0]  w_remain;
  logic [2:0]  w_count_next;
  logic [15:0] w_push_first;
  logic [15:0] w_push_second;
  logic [15:0] w_q_next [c_DEPTH];
  logic        w_unused_bits;

  // Bit 0 of a redirect target never matters for halfword-aligned code.
  assign w_unused_bits = flush_pc[0];

  // Head decode: the low two bits of the head halfword select 16- vs 32-bit.
  always_comb begin
    w_head   = (r_count != 3'd0) ? r_q[0] : 16'h0000;
    w_entry1 = r_q[1];
    w_is32   = (w_head[1:0] == 2'b11);
    w_valid  = !flush && ((!w_is32 && (r_count >= 3'd1)) ||
                          ( w_is32 && (r_count >= 3'd2)));
    w_pop_n  = 2'd0;
    if (w_valid && instr_ready) begin
      w_pop_n = w_is32 ? 2'd2 : 2'd1;
    end
  end

  assign dec_in           = w_head;
  assign instr_valid      = w_valid;
  assign instr            = w_valid ? (w_is32 ? {w_entry1, w_head} : dec_out) : 32'h0000_0000;
  assign instr_pc         = r_head_pc;
  assign instr_compressed = w_valid && !w_is32;

  // Fetch FSM next state, request generation and number of halfwords to push.
  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    w_push_n     = 2'd0;
    case (r_state)
      ST_IDLE: begin
        w_req_valid = r_run && (r_count <= 3'd2) && !flush;
        if (w_req_valid && imem_req_ready) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          w_state_next = ST_IDLE;
          if (!flush) begin
            w_push_n = r_drop_low ? 2'd1 : 2'd2;
          end
        end else if (flush) begin
          w_state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_resp_valid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept       = w_req_valid && imem_req_ready;
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_addr;

  // Queue next state: shift out popped entries, then append pushed halfwords.
  always_comb begin
    logic [2:0] v_src;
    w_remain      = r_count - {1'b0, w_pop_n};
    w_count_next  = w_remain + {1'b0, w_push_n};
    w_push_first  = r_drop_low ? imem_resp_data[31:16] : imem_resp_data[15:0];
    w_push_second = imem_resp_data[31:16];
    v_src         = 3'd0;
    for (int i = 0; i < c_DEPTH; i++) begin
      v_src = 3'(i) + {1'b0, w_pop_n};
      if (v_src < 3'(c_DEPTH)) begin
        w_q_next[i] = r_q[v_src[1:0]];
      end else begin
        w_q_next[i] = 16'h0000;
      end
      if ((w_push_n != 2'd0) && (3'(i) == w_remain)) begin
        w_q_next[i] = w_push_first;
      end
      if ((w_push_n == 2'd2) && (3'(i) == (w_remain + 3'd1))) begin
        w_q_next[i] = w_push_second;
      end
    end
  end

  // State registers; a flush empties the queue and re-points both PCs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_count      <= 3'd0;
      r_head_pc    <= {RESET_PC[31:1], 1'b0};
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_drop_low   <= RESET_PC[1];
      for (int i = 0; i < c_DEPTH; i++) begin
        r_q[i] <= 16'h0000;
      end
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
      if (flush) begin
        r_count      <= 3'd0;
        r_head_pc    <= {flush_pc[31:1], 1'b0};
        r_fetch_addr <= {flush_pc[31:2], 2'b00};
        r_drop_low   <= flush_pc[1];
      end else begin
        r_count <= w_count_next;
        for (int i = 0; i < c_DEPTH; i++) begin
          r_q[i] <= w_q_next[i];
        end
        if (w_pop_n != 2'd0) begin
          r_head_pc <= r_head_pc + ((w_pop_n == 2'd2) ? 32'd4 : 32'd2);
        end
        if (w_accept) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
        end
        if (w_push_n != 2'd0) begin
          r_drop_low <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_fetch_aligner                                         |
// | Description : Self-checking bench for fetch_aligner with a word memory |
// |               model, a small decompressor and an instruction scoreboard|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [15:0] dec_in;
  logic [31:0] dec_out;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        comp;
    logic [15:0] hw;
    int          need_resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] acc_q[$];
  logic [31:0] mem [128];
  int          checks = 0;
  int          failures = 0;
  int          n_xfer = 0;
  int          n_resp = 0;
  int          lat = 1;
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .dec_in           (dec_in),
    .dec_out          (dec_out),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed)
  );

  // Minimal decompressor: c.li and c.addi expand exactly, others get a marker.
  function automatic logic [31:0] expand(input logic [15:0] hw);
    logic [11:0] imm;
    imm = {{7{hw[12]}}, hw[6:2]};
    if (hw[15:13] == 3'b010 && hw[1:0] == 2'b01) return {imm, 5'd0, 3'b000, hw[11:7], 7'h13};
    if (hw[15:13] == 3'b000 && hw[1:0] == 2'b01) return {imm, hw[11:7], 3'b000, hw[11:7], 7'h13};
    return {16'hC0DE, hw};
  endfunction

  assign dec_out = expand(dec_in);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_c(input logic [31:0] pc, input logic [15:0] hw);
    exp_t e;
    e.ins = expand(hw); e.pc = pc; e.comp = 1'b1; e.hw = hw; e.need_resp = 0;
    sb.push_back(e);
  endtask

  task automatic expect_w(input logic [31:0] pc, input logic [31:0] w, input int need);
    exp_t e;
    e.ins = w; e.pc = pc; e.comp = 1'b0; e.hw = w[15:0]; e.need_resp = need;
    sb.push_back(e);
  endtask

  // Let decode accept until the transfer counter reaches n, then stall it.
  task automatic take_until(input int n);
    instr_ready = 1'b1;
    for (int k = 0; k < 400 && n_xfer < n; k++) begin
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    chk("xfer_budget", (n_xfer >= n), 1);
  endtask

  // One-cycle redirect issued while no fetch is in flight.
  task automatic redirect(input logic [31:0] pc);
    for (int k = 0; k < 50 && pend; k++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    flush_pc = pc;
    @(negedge clk);
    chk("flush_no_req", imem_req_valid, 0);
    chk("flush_no_valid", instr_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Memory model: one outstanding read, response lat cycles after acceptance.
  initial begin
    int timer;
    logic [31:0] paddr;
    timer = 0;
    paddr = 32'h0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (reset_n) begin
        if (pend) begin
          timer--;
          if (timer == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = mem[paddr[8:2]];
            pend = 1'b0;
            n_resp++;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", pend, 0);
          chk("addr_aligned", imem_req_addr[1:0], 0);
          pend = 1'b1;
          timer = lat;
          paddr = imem_req_addr;
          acc_q.push_back(imem_req_addr);
        end
      end
    end
  end

  // Output monitor: hold-stability under backpressure and scoreboard compare.
  initial begin
    logic pv, pr, pf, pc_d;
    logic [31:0] pi, ppc;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; pc_d = 1'b0; pi = 32'h0; ppc = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pv && !pr && !pf && !flush) begin
          chk("hold_valid", instr_valid, 1);
          chk("hold_instr", instr, pi);
          chk("hold_pc", instr_pc, ppc);
          chk("hold_comp", instr_compressed, pc_d);
        end
        if (instr_valid && instr_ready) begin
          chk("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instr", instr, e.ins);
            chk("instr_pc", instr_pc, e.pc);
            chk("instr_comp", instr_compressed, e.comp);
            chk("dec_in", dec_in, e.hw);
            if (e.need_resp > 0) chk("straddle_after_word2", (n_resp >= e.need_resp), 1);
          end
          n_xfer++;
        end
      end
      pv = instr_valid; pr = instr_ready; pf = flush;
      pi = instr; ppc = instr_pc; pc_d = instr_compressed;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int idx;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0001_0001;
    mem[0]  = 32'h00A0_0093;
    mem[8]  = 32'h0505_4505;
    mem[16] = 32'h0093_4505;
    mem[17] = 32'h0001_00A0;
    for (int i = 32; i < 40; i++) mem[i] = 32'h0505_4505;
    mem[48] = 32'h00A0_0093;
    mem[64] = 32'h0505_FFFF;
    mem[65] = 32'h00A0_0093;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_comp", instr_compressed, 0);

    // Aligned 32-bit fetch from RESET_PC.
    expect_w(32'h0, 32'h00A0_0093, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("req_cycle0", imem_req_valid, 0);
    @(negedge clk);
    chk("req_cycle1", imem_req_valid, 1);
    chk("req_addr0", imem_req_addr, 0);
    take_until(1);
    chk("first_acc_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 0);

    // Two compressed instructions in one word.
    redirect(32'h20);
    expect_c(32'h20, 16'h4505);
    expect_c(32'h22, 16'h0505);
    take_until(3);

    // 32-bit instruction straddling a word boundary, slow memory.
    lat = 3;
    redirect(32'h40);
    base = n_resp;
    expect_c(32'h40, 16'h4505);
    expect_w(32'h42, 32'h00A0_0093, base + 2);
    take_until(5);

    // Flush while a response is outstanding; low halfword of target dropped.
    redirect(32'h180);
    for (int k = 0; k < 50 && !pend; k++) begin
      @(posedge clk); #1;
    end
    chk("pend_before_flush", pend, 1);
    idx = acc_q.size();
    flush = 1'b1;
    flush_pc = 32'h102;
    @(negedge clk);
    chk("wflush_no_req", imem_req_valid, 0);
    chk("wflush_no_valid", instr_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    expect_c(32'h102, 16'h0505);
    expect_w(32'h104, 32'h00A0_0093, 0);
    take_until(7);
    chk("post_flush_addr", (acc_q.size() > idx) ? acc_q[idx] : 32'hFFFF_FFFF, 32'h100);

    // Decode backpressure with a stream of compressed instructions.
    lat = 1;
    redirect(32'h80);
    for (int k = 0; k < 16; k++) expect_c(32'h80 + 2 * k, (k % 2 == 0) ? 16'h4505 : 16'h0505);
    take_until(9);
    repeat (6) @(negedge clk);
    chk("bp_queue_full_no_req", imem_req_valid, 0);
    chk("bp_valid_held", instr_valid, 1);
    @(posedge clk); #1;
    take_until(23);

    // Memory not ready for 4 cycles: request held with a stable address.
    imem_req_ready = 1'b0;
    redirect(32'hC0);
    idx = acc_q.size();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 1);
      chk("stall_req_addr", imem_req_addr, 32'hC0);
    end
    expect_w(32'hC0, 32'h00A0_0093, 0);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_one_accept", acc_q.size(), idx + 1);
    chk("stall_acc_addr", (acc_q.size() > idx) ? acc_q[idx] : 32'hFFFF_FFFF, 32'hC0);
    take_until(24);

    repeat (5) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
